// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared core constants and types
// Pipeline depth and the perf-counter bus exposed by the datapath top.
package common;

  localparam int PIPE_STAGES = 5;
  localparam int PIPE_CNT_W  = 32;

  typedef struct packed {
    logic [PIPE_CNT_W-1:0] cyc;
    logic [PIPE_CNT_W-1:0] ret;
    logic [PIPE_CNT_W-1:0] stall;
    logic [PIPE_CNT_W-1:0] flush;
  } pipe_perf_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - wrap-around event counter
// Clear wins over a same-cycle increment.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - elastic pipeline sequencing controller
// Per-stage valid/accept handshake, redirect flush and perf counters.
module pipe_ctrl
  import common::*;
#(
  parameter  int STAGES = PIPE_STAGES,
  parameter  int CNT_W  = PIPE_CNT_W,
  localparam int SW     = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STAGES-1:0] busy,
  input  logic              redirect_en,
  input  logic [SW-1:0]     redirect_stage,
  output logic [STAGES-1:0] valid,
  output logic [STAGES-1:0] advance,
  output logic              retire,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  ret_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [SW:0] LAST = (SW+1)'(STAGES - 1);

  logic [SW:0]       rs_eff;
  logic [STAGES-1:0] flush;
  logic [STAGES-1:0] leave;
  logic [STAGES-1:0] accept;

  always_comb begin
    rs_eff = ({1'b0, redirect_stage} > LAST) ? LAST : {1'b0, redirect_stage};
    flush  = '0;
    for (int i = 0; i < STAGES; i++) begin
      flush[i] = redirect_en & ((SW+1)'(i) < rs_eff);
    end
  end

  // Backpressure chain, oldest to youngest, resolved in one cycle.
  always_comb begin
    logic down_ok;
    down_ok = 1'b1;
    leave   = '0;
    accept  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      leave[i]  = valid[i] & ~busy[i] & down_ok & ~flush[i];
      accept[i] = ~valid[i] | leave[i];
      down_ok   = accept[i];
    end
  end

  assign in_ready = rst & accept[0] & ~redirect_en;
  assign advance  = rst ? (accept & ~flush) : '0;
  assign retire   = rst & leave[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic v_in;
    logic v_d;
    logic v_q;

    if (g == 0) begin : g_head
      assign v_in = in_valid & in_ready;
    end else begin : g_body
      assign v_in = leave[g-1];
    end

    always_comb begin
      v_d = v_q;
      if (flush[g]) begin
        v_d = 1'b0;
      end else if (advance[g]) begin
        v_d = v_in;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        v_q <= 1'b0;
      end else begin
        v_q <= v_d;
      end
    end

    assign valid[g] = v_q;
  end

  pipe_perf_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .clr (cnt_clr),
    .cnt (cyc_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_ret_cnt (
    .clk (clk),
    .rst (rst),
    .inc (retire),
    .clr (cnt_clr),
    .cnt (ret_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_valid & ~in_ready),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_en),
    .clr (cnt_clr),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
// Slot-occupancy reference model feeds a queue drained by a negedge monitor.
module tb_pipe_ctrl;
  import common::*;

  localparam int S  = 5;
  localparam int CW = 32;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [S-1:0]  busy = '0;
  logic          redirect_en = 1'b0;
  logic [SW-1:0] redirect_stage = '0;
  logic [S-1:0]  valid;
  logic [S-1:0]  advance;
  logic          retire;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] ret_cnt;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .busy           (busy),
    .redirect_en    (redirect_en),
    .redirect_stage (redirect_stage),
    .valid          (valid),
    .advance        (advance),
    .retire         (retire),
    .cnt_clr        (cnt_clr),
    .cyc_cnt        (cyc_cnt),
    .ret_cnt        (ret_cnt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          chk_state;
    logic [S-1:0]  valid;
    logic [S-1:0]  adv;
    logic          rdy;
    logic          ret;
    logic [CW-1:0] cyc;
    logic [CW-1:0] retc;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  // Model: each slot holds the id of the instruction in it, or -1 when empty.
  int            occ[S];
  int            next_id = 0;
  int            last_ret_id = -1;
  logic [CW-1:0] m_cyc = '0;
  logic [CW-1:0] m_ret = '0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [S-1:0] b, input logic re,
                       input logic [SW-1:0] rs, input logic clr, input logic r);
    exp_t e;
    int   rse;
    bit   fl[S];
    bit   lv[S];
    bit   ac[S];
    bit   room;
    bit   rdy;
    int   nocc[S];
    @(posedge clk);
    #1;
    in_valid = v; busy = b; redirect_en = re; redirect_stage = rs; cnt_clr = clr; rst = r;

    rse = (int'(rs) > S - 1) ? S - 1 : int'(rs);
    for (int i = 0; i < S; i++) fl[i] = re && (i < rse);
    room = 1'b1;
    for (int i = S - 1; i >= 0; i--) begin
      lv[i] = (occ[i] >= 0) && !b[i] && !fl[i] && room;
      ac[i] = (occ[i] < 0) || lv[i];
      room  = ac[i];
    end
    rdy = r && ac[0] && !re;

    e.chk_state = r;
    e.rdy = rdy;
    e.ret = r && lv[S-1];
    for (int i = 0; i < S; i++) begin
      e.valid[i] = occ[i] >= 0;
      e.adv[i]   = r && ac[i] && !fl[i];
    end
    e.cyc = m_cyc; e.retc = m_ret; e.stall = m_stall; e.flush = m_flush;
    sbq.push_back(e);

    if (!r) begin
      for (int i = 0; i < S; i++) occ[i] = -1;
      m_cyc = '0; m_ret = '0; m_stall = '0; m_flush = '0;
    end else begin
      if (lv[S-1]) begin
        if (occ[S-1] <= last_ret_id) begin
          bad++;
          $display("FAIL model_order id=%0d last=%0d", occ[S-1], last_ret_id);
        end
        last_ret_id = occ[S-1];
      end
      for (int i = 0; i < S; i++) begin
        if (fl[i]) nocc[i] = -1;
        else if (ac[i]) begin
          if (i == 0) nocc[i] = (v && rdy) ? next_id : -1;
          else        nocc[i] = lv[i-1] ? occ[i-1] : -1;
        end else nocc[i] = occ[i];
      end
      if (v && rdy) next_id++;
      for (int i = 0; i < S; i++) occ[i] = nocc[i];
      m_cyc   = clr ? '0 : m_cyc + 1;
      m_ret   = clr ? '0 : m_ret + CW'(lv[S-1]);
      m_stall = clr ? '0 : m_stall + CW'(v && !rdy);
      m_flush = clr ? '0 : m_flush + CW'(re);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("in_ready", CW'(in_ready), CW'(e.rdy));
      chk("advance", CW'(advance), CW'(e.adv));
      chk("retire", CW'(retire), CW'(e.ret));
      if (e.chk_state) begin
        chk("valid", CW'(valid), CW'(e.valid));
        chk("cyc_cnt", cyc_cnt, e.cyc);
        chk("ret_cnt", ret_cnt, e.retc);
        chk("stall_cnt", stall_cnt, e.stall);
        chk("flush_cnt", flush_cnt, e.flush);
      end
    end
  end

  initial begin
    logic [S-1:0] rb;
    for (int i = 0; i < S; i++) occ[i] = -1;

    repeat (2) drive(0, '0, 0, 0, 0, 0);
    repeat (20) drive(1, '0, 0, 0, 0, 1);
    repeat (3) drive(1, 5'b01000, 0, 0, 0, 1);
    repeat (4) drive(1, '0, 0, 0, 0, 1);

    drive(1, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    drive(1, 5'b10000, 0, 0, 0, 1);
    repeat (6) drive(1, 5'b10000, 0, 0, 0, 1);
    repeat (3) drive(1, '0, 0, 0, 0, 1);

    repeat (6) drive(1, '0, 0, 0, 0, 1);
    drive(1, '0, 1, 3'd3, 0, 1);
    repeat (4) drive(1, '0, 0, 0, 0, 1);
    drive(1, 5'b01000, 1, 3'd3, 0, 1);
    repeat (3) drive(1, '0, 0, 0, 0, 1);

    repeat (6) drive(1, '0, 0, 0, 0, 1);
    drive(1, '0, 1, 3'd7, 1, 1);
    repeat (3) drive(1, '0, 0, 0, 0, 1);

    drive(1, '0, 0, 0, 0, 0);
    repeat (3) drive(1, '0, 0, 0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < S; i++) rb[i] = ($urandom_range(0, 4) == 0);
      drive($urandom_range(0, 3) != 0, rb, $urandom_range(0, 19) == 0,
            SW'($urandom_range(0, 7)), $urandom_range(0, 49) == 0,
            $urandom_range(0, 199) != 0);
    end

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
